uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Control and buffering layer between `uart_rx` and the host. It owns the receiver's frame-format configuration and applies changes only while `uart_rx` is idle, so no frame is ever sampled with a mixed format. Received bytes and their error flags go into a small FIFO with a valid/ready read port. Saturating counters track parity errors, frame errors and overflow drops.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of each statistics counter.
- `CFG_RST`, 5'b00001: config after reset, `{stop_bit_size, parity_mode[1:0], parity_en, data_size}`; the default is 8 data bits, no parity, 1 stop bit.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_wr`  in  1  one-cycle request to load a new configuration.
- `cfg_data`  in  5  requested config, same packing as `CFG_RST`.
- `cfg_busy`  out  1  a configuration is pending and not yet applied.
- `data_size`, `parity_en`, `stop_bit_size`  out  1 each  applied config to `uart_rx`.
- `parity_mode`  out  2  applied config to `uart_rx`: 11 odd, 10 even, 01 mark, 00 space.
- `rx_ready`  in  1  from `uart_rx`; high means idle, no frame in progress.
- `rx_new_data`  in  1  one-cycle pulse from `uart_rx`; `rx_data` and the error flags are valid in that cycle.
- `rx_data`  in  8  received byte; bit 7 is 0 in 7-bit mode.
- `rx_err_crc`, `rx_err_frame`  in  1 each  error flags for the frame.
- `rd_valid`  out  1  FIFO head is valid.
- `rd_data`  out  10  `{err_frame, err_crc, data[7:0]}` of the FIFO head.
- `rd_ready`  in  1  host accepts the head.
- `fifo_flush`  in  1  one-cycle pulse; empties the FIFO.
- `fifo_level`  out  $clog2(DEPTH)+1  current number of entries.
- `crc_cnt`, `frame_cnt`, `drop_cnt`  out  CNT_W each  saturating statistics counters.
- `cnt_clr`  in  1  one-cycle pulse; zeroes all three counters.

## Operation
- Config FSM has two states, RUN and PEND.
  - RUN: on `cfg_wr`, latch `cfg_data` into the pending register and go to PEND.
  - PEND: a further `cfg_wr` overwrites the pending value and the FSM stays in PEND.
  - PEND: when `rx_ready`=1 and `rx_new_data`=0 in the same cycle, copy pending to the applied outputs and go to RUN.
  - `cfg_busy` = (state == PEND).
- FIFO push: on `rx_new_data`, push `{rx_err_frame, rx_err_crc, rx_data}`.
  - If full and no pop in the same cycle, drop the entry and increment `drop_cnt`.
  - If full and a pop occurs in the same cycle, accept the push; level is unchanged.
- FIFO pop: occurs when `rd_valid` && `rd_ready`.
- Wrap-around: read and write pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from `fifo_level`.
- `fifo_flush`: sets level to 0 and aligns the pointers. A push or pop in the same cycle is discarded, and a discarded push does not increment `drop_cnt`.
- Counters: `crc_cnt` increments on `rx_new_data` && `rx_err_crc`; `frame_cnt` increments on `rx_new_data` && `rx_err_frame`.
  - All three counters saturate at 2^CNT_W−1.
  - If `cnt_clr` coincides with an increment, `cnt_clr` wins and the result is 0.
- Errored frames are still stored in the FIFO; dropping them is the host's decision.

## Timing
- Reset values:
  - FSM in RUN, `cfg_busy`=0.
  - Config outputs = `CFG_RST`.
  - FIFO empty: `rd_valid`=0, `rd_data`=0, `fifo_level`=0.
  - All counters 0.
  - Reset in the middle of PEND discards the pending config.
- Config latency: with `cfg_wr` in cycle N, `cfg_busy`=1 from N+1. If `rx_ready`=1 at N+1, the new config is visible and `cfg_busy`=0 at N+2; otherwise both happen one cycle after the first qualifying cycle.
- FIFO: a push in cycle N gives `rd_valid`=1 and valid `rd_data` at N+1; the FIFO is first-word fall-through. A pop in cycle N presents the next head, or deasserts `rd_valid`, at N+1.
- `rd_data` is held stable while `rd_valid`=1 && `rd_ready`=0.
- Counters and `fifo_level` update one cycle after the causing event.

## Structure
- Shared package `uart_pkg` holds:
  - cfg field bit positions and the 5-bit cfg type;
  - the `parity_mode` encodings;
  - the FSM state enum (`RUN`, `PEND`).
- Sub-module `uart_rx_fifo` (parameter `DEPTH`, width 10) implements push, pop, flush and level. The FSM and the counters stay in the top level.
- The top instantiates `uart_rx_fifo` only; `uart_rx` and `uart_clk_gen` are instantiated alongside it by the integrating level.

## Test plan
- Reset, then idle → config outputs = 5'b00001, `rd_valid`=0, all counters 0.
- `cfg_wr` with 5'b00111 (parity on, mark) while a 0x95 frame is mid-reception (`rx_ready`=0) → outputs unchanged until the frame ends. Outputs become 5'b00111 two cycles after `rx_ready` rises; `cfg_busy` falls in the same cycle.
- Five `rx_new_data` pulses (0x01–0x05), `rd_ready`=0, DEPTH=4 → `fifo_level`=4 and `drop_cnt`=1. Draining returns 0x001–0x004 in order.
- Frame 0x95 with `rx_err_crc`=1, then 0x95 with `rx_err_frame`=1 → `rd_data`=0x195 then 0x295; `crc_cnt`=1, `frame_cnt`=1.
- FIFO full, `rx_new_data` and pop in the same cycle → level stays 4 and `drop_cnt` is unchanged. Then `fifo_flush` together with `rx_new_data` → level 0, `drop_cnt` unchanged.
- Pulse `rx_new_data` with `rx_err_crc`=1 a total of 300 times with CNT_W=8 → `crc_cnt`=255. Then `cnt_clr` together with one more errored frame → `crc_cnt`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: config packing, parity
// encodings and the config FSM state type.
package uart_pkg;

  typedef logic [4:0] cfg_t;

  localparam int unsigned CFG_DATA_SIZE = 0;
  localparam int unsigned CFG_PAR_EN    = 1;
  localparam int unsigned CFG_PAR_MODE  = 2;
  localparam int unsigned CFG_STOP_BITS = 4;

  localparam logic [1:0] PAR_SPACE = 2'b00;
  localparam logic [1:0] PAR_MARK  = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_ODD   = 2'b11;

  typedef enum logic {
    RUN,
    PEND
  } cfg_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO for received bytes with flush and level
// reporting; a push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       flush,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_ok;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign pop     = !empty && rd_ready;
  assign push_ok = push && (!full || pop);
  // A push discarded by flush is not an overflow.
  assign drop    = push && full && !pop && !flush;

  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];
  assign level    = level_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receiver control layer: defers config changes until uart_rx is idle,
// buffers received frames and keeps saturating error statistics.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter logic [4:0]  CFG_RST = 5'b00001
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr,
  input  logic [4:0]               cfg_data,
  output logic                     cfg_busy,
  output logic                     data_size,
  output logic                     parity_en,
  output logic [1:0]               parity_mode,
  output logic                     stop_bit_size,
  input  logic                     rx_ready,
  input  logic                     rx_new_data,
  input  logic [7:0]               rx_data,
  input  logic                     rx_err_crc,
  input  logic                     rx_err_frame,
  output logic                     rd_valid,
  output logic [9:0]               rd_data,
  input  logic                     rd_ready,
  input  logic                     fifo_flush,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         crc_cnt,
  output logic [CNT_W-1:0]         frame_cnt,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     cnt_clr
);

  cfg_state_t state, state_nxt;
  cfg_t       cfg_q, cfg_nxt;
  cfg_t       pend_q, pend_nxt;
  logic       fifo_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      cfg_q  <= CFG_RST;
      pend_q <= CFG_RST;
    end else begin
      state  <= state_nxt;
      cfg_q  <= cfg_nxt;
      pend_q <= pend_nxt;
    end
  end

  // A new write while pending takes priority over applying the old value.
  always_comb begin
    state_nxt = state;
    cfg_nxt   = cfg_q;
    pend_nxt  = pend_q;
    case (state)
      RUN: begin
        if (cfg_wr) begin
          pend_nxt  = cfg_data;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (cfg_wr) begin
          pend_nxt = cfg_data;
        end else if (rx_ready && !rx_new_data) begin
          cfg_nxt   = pend_q;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign cfg_busy      = (state == PEND);
  assign data_size     = cfg_q[CFG_DATA_SIZE];
  assign parity_en     = cfg_q[CFG_PAR_EN];
  assign parity_mode   = cfg_q[CFG_PAR_MODE +: 2];
  assign stop_bit_size = cfg_q[CFG_STOP_BITS];

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_new_data),
    .push_data ({rx_err_frame, rx_err_crc, rx_data}),
    .flush     (fifo_flush),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .level     (fifo_level),
    .drop      (fifo_drop)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      crc_cnt   <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      crc_cnt   <= sat_inc(crc_cnt, rx_new_data && rx_err_crc);
      frame_cnt <= sat_inc(frame_cnt, rx_new_data && rx_err_frame);
      drop_cnt  <= sat_inc(drop_cnt, fifo_drop);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: config deferral, FIFO order/overflow/flush
// and counter saturation/clear.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_wr;
  logic [4:0] cfg_data;
  logic       cfg_busy;
  logic       data_size, parity_en, stop_bit_size;
  logic [1:0] parity_mode;
  logic       rx_ready, rx_new_data, rx_err_crc, rx_err_frame;
  logic [7:0] rx_data;
  logic       rd_valid, rd_ready, fifo_flush, cnt_clr;
  logic [9:0] rd_data;
  logic [2:0] fifo_level;
  logic [7:0] crc_cnt, frame_cnt, drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DEPTH   (4),
    .CNT_W   (8),
    .CFG_RST (5'b00001)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_wr        (cfg_wr),
    .cfg_data      (cfg_data),
    .cfg_busy      (cfg_busy),
    .data_size     (data_size),
    .parity_en     (parity_en),
    .parity_mode   (parity_mode),
    .stop_bit_size (stop_bit_size),
    .rx_ready      (rx_ready),
    .rx_new_data   (rx_new_data),
    .rx_data       (rx_data),
    .rx_err_crc    (rx_err_crc),
    .rx_err_frame  (rx_err_frame),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_ready      (rd_ready),
    .fifo_flush    (fifo_flush),
    .fifo_level    (fifo_level),
    .crc_cnt       (crc_cnt),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt),
    .cnt_clr       (cnt_clr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] cfg_out();
    return {stop_bit_size, parity_mode, parity_en, data_size};
  endfunction

  initial begin
    rst = 1'b1; cfg_wr = 0; cfg_data = '0; rx_ready = 1; rx_new_data = 0;
    rx_data = '0; rx_err_crc = 0; rx_err_frame = 0; rd_ready = 0;
    fifo_flush = 0; cnt_clr = 0;
    step(); step();
    rst = 1'b0;
    step();

    check("rst_cfg", 32'(cfg_out()), 32'h01);
    check("rst_busy", 32'(cfg_busy), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_data", 32'(rd_data), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_cnts", {8'h0, crc_cnt, frame_cnt, drop_cnt}, 0);

    // config request during a frame
    rx_ready = 0; cfg_wr = 1; cfg_data = 5'b00111;
    step();
    cfg_wr = 0;
    check("pend_busy", 32'(cfg_busy), 1);
    check("pend_cfg_held", 32'(cfg_out()), 32'h01);
    step(); step();
    check("pend_cfg_held2", 32'(cfg_out()), 32'h01);
    rx_ready = 1; rx_new_data = 1; rx_data = 8'h95;
    step();
    rx_new_data = 0;
    check("end_frame_cfg", 32'(cfg_out()), 32'h01);
    check("end_frame_busy", 32'(cfg_busy), 1);
    check("first_push", 32'(rd_data), 32'h095);
    rd_ready = 1;
    step();
    rd_ready = 0;
    check("applied_cfg", 32'(cfg_out()), 32'h07);
    check("applied_busy", 32'(cfg_busy), 0);
    check("popped_level", 32'(fifo_level), 0);

    // overflow
    for (int i = 1; i <= 5; i++) begin
      rx_new_data = 1; rx_data = 8'(i);
      step();
    end
    rx_new_data = 0;
    check("ovf_level", 32'(fifo_level), 4);
    check("ovf_drop", 32'(drop_cnt), 1);
    step();
    check("hold_data", 32'(rd_data), 32'h001);
    rd_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 32'(rd_valid), 1);
      check("drain_data", 32'(rd_data), 32'(i));
      step();
    end
    rd_ready = 0;
    check("drained_valid", 32'(rd_valid), 0);
    check("drained_level", 32'(fifo_level), 0);

    // errored frames
    rx_new_data = 1; rx_data = 8'h95; rx_err_crc = 1;
    step();
    rx_err_crc = 0; rx_err_frame = 1;
    step();
    rx_new_data = 0; rx_err_frame = 0;
    check("crc_cnt1", 32'(crc_cnt), 1);
    check("frame_cnt1", 32'(frame_cnt), 1);
    check("err_head1", 32'(rd_data), 32'h195);
    rd_ready = 1;
    step();
    check("err_head2", 32'(rd_data), 32'h295);
    step();
    rd_ready = 0;
    check("err_empty", 32'(fifo_level), 0);

    // full with simultaneous push and pop, then flush with push
    for (int i = 0; i < 4; i++) begin
      rx_new_data = 1; rx_data = 8'(8'h10 + i);
      step();
    end
    check("full_level", 32'(fifo_level), 4);
    rx_data = 8'h20; rd_ready = 1;
    step();
    rd_ready = 0;
    check("pushpop_level", 32'(fifo_level), 4);
    check("pushpop_drop", 32'(drop_cnt), 1);
    check("pushpop_head", 32'(rd_data), 32'h011);
    fifo_flush = 1; rx_data = 8'h30;
    step();
    fifo_flush = 0; rx_new_data = 0;
    check("flush_level", 32'(fifo_level), 0);
    check("flush_valid", 32'(rd_valid), 0);
    check("flush_drop", 32'(drop_cnt), 1);
    rx_new_data = 1; rx_data = 8'h44;
    step();
    rx_new_data = 0;
    check("post_flush_head", 32'(rd_data), 32'h044);
    check("post_flush_level", 32'(fifo_level), 1);
    rd_ready = 1;
    step();

    // crc counter saturation (crc_cnt starts at 1), FIFO kept drained
    rx_new_data = 1; rx_err_crc = 1; rx_data = 8'h55;
    for (int i = 0; i < 253; i++) step();
    check("crc_254", 32'(crc_cnt), 254);
    for (int i = 0; i < 47; i++) step();
    check("crc_sat", 32'(crc_cnt), 255);
    check("no_drop", 32'(drop_cnt), 1);
    cnt_clr = 1;
    step();
    cnt_clr = 0; rx_new_data = 0; rx_err_crc = 0;
    check("clr_crc", 32'(crc_cnt), 0);
    check("clr_frame", 32'(frame_cnt), 0);
    check("clr_drop", 32'(drop_cnt), 0);

    // reset during PEND discards the pending config
    rx_ready = 0; cfg_wr = 1; cfg_data = 5'b11110;
    step();
    cfg_wr = 0; rst = 1;
    step();
    rst = 0; rx_ready = 1;
    step(); step();
    check("rst_pend_cfg", 32'(cfg_out()), 32'h01);
    check("rst_pend_busy", 32'(cfg_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
